// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } fetch_state_t;

    // Upper fields of the bus request tag; the low byte is always zero for fetches.
    localparam logic [1:0] READ   = 2'b10;
    localparam logic [2:0] MEMORY = 3'b001;

    function automatic logic [63:0] line_align(input logic [63:0] addr,
                                               input int unsigned line_bytes);
        return addr & ~(64'(line_bytes) - 64'd1);
    endfunction

endpackage

// File: rtl/fetch_stream_unit_if.sv
// System-bus request/response channel between the fetch unit and memory.
interface fetch_stream_unit_if #(
    parameter int TAG_BITS  = 13,
    parameter int BEAT_BITS = 64
);
    logic                 req_cyc;
    logic [63:0]          req_addr;
    logic [TAG_BITS-1:0]  req_tag;
    logic                 req_ack;
    logic                 resp_cyc;
    logic [BEAT_BITS-1:0] resp_data;
    logic                 resp_ack;

    modport master (
        output req_cyc,
        output req_addr,
        output req_tag,
        input  req_ack,
        input  resp_cyc,
        input  resp_data,
        output resp_ack
    );

    modport slave (
        input  req_cyc,
        input  req_addr,
        input  req_tag,
        output req_ack,
        output resp_cyc,
        output resp_data,
        input  resp_ack
    );

endinterface

// File: rtl/fetch_ring_buffer.sv
// Circular byte store: one aligned beat written per cycle, rotated decode window read out.
module fetch_ring_buffer #(
    parameter int BUF_BYTES     = 128,
    parameter int BEAT_BITS     = 64,
    parameter int DECODE_WINDOW = 15
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [$clog2(BUF_BYTES)-1:0]  wr_ptr,
    input  logic [BEAT_BITS-1:0]          wr_data,
    input  logic [$clog2(BUF_BYTES)-1:0]  rd_ptr,
    output logic [DECODE_WINDOW*8-1:0]    window
);
    localparam int PTR_W      = $clog2(BUF_BYTES);
    localparam int BEAT_BYTES = BEAT_BITS / 8;

    logic [7:0] mem [BUF_BYTES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BEAT_BYTES; i++) begin
                mem[PTR_W'(wr_ptr + PTR_W'(i))] <= wr_data[i*8 +: 8];
            end
        end
    end

    // Window byte i is taken modulo the buffer size so it wraps past the top.
    always_comb begin
        window = '0;
        for (int i = 0; i < DECODE_WINDOW; i++) begin
            window[i*8 +: 8] = mem[PTR_W'(rd_ptr + PTR_W'(i))];
        end
    end

endmodule

// File: rtl/fetch_stream_unit.sv
// Instruction-fetch front end: line requests, beat buffering with leading-byte skip,
// decode window with variable consume, and redirect flush of in-flight lines.
module fetch_stream_unit
    import fetch_pkg::*;
#(
    parameter int LINE_BYTES    = 64,
    parameter int BEAT_BITS     = 64,
    parameter int BUF_BYTES     = 128,
    parameter int DECODE_WINDOW = 15,
    parameter int TAG_BITS      = 13
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [63:0]                         entry,
    input  logic                                redirect,
    input  logic [63:0]                         redirect_rip,
    fetch_stream_unit_if.master                 bus,
    output logic [DECODE_WINDOW*8-1:0]          window_bytes,
    output logic [$clog2(DECODE_WINDOW+1)-1:0]  window_valid,
    input  logic [$clog2(DECODE_WINDOW+1)-1:0]  consume
);
    localparam int BEAT_BYTES = BEAT_BITS / 8;
    localparam int BEATS      = LINE_BYTES / BEAT_BYTES;
    localparam int PTR_W      = $clog2(BUF_BYTES);
    localparam int CNT_W      = PTR_W + 1;
    localparam int WV_W       = $clog2(DECODE_WINDOW + 1);
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int BOFF_W     = $clog2(BEAT_BYTES);
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

    function automatic logic [WV_W-1:0] sat_window(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(DECODE_WINDOW)) ? WV_W'(DECODE_WINDOW) : WV_W'(c);
    endfunction

    function automatic logic [WV_W-1:0] clamp_consume(input logic [WV_W-1:0] c,
                                                      input logic [WV_W-1:0] lim);
        return (c > lim) ? lim : c;
    endfunction

    fetch_state_t       state;
    logic               req_pending;
    logic [63:0]        req_line;
    logic [63:0]        line_rip;
    logic [OFF_W-1:0]   skip;
    logic               stale;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic               beat_fire;
    logic               last_beat;
    logic               beat_wr;
    logic [BEAT_W-1:0]  skip_beat;
    logic [PTR_W-1:0]   skip_adv;
    logic [WV_W-1:0]    consume_eff;
    logic [CNT_W-1:0]   free_bytes;
    logic [CNT_W-1:0]   wr_bytes;

    assign bus.req_cyc  = req_pending;
    assign bus.req_addr = req_line;
    assign bus.req_tag  = TAG_BITS'({READ, MEMORY, 8'b0});
    assign bus.resp_ack = bus.resp_cyc;

    assign window_valid = sat_window(count);

    // Beats wholly before the fetch target are dropped; the beat holding it
    // is stored whole and the read pointer steps over the leading bytes.
    always_comb begin
        consume_eff = clamp_consume(consume, window_valid);
        beat_fire   = (state == RESP) && bus.resp_cyc;
        last_beat   = beat_fire && (beat_cnt == BEAT_W'(BEATS - 1));
        skip_beat   = BEAT_W'(skip >> BOFF_W);
        beat_wr     = beat_fire && !stale && !redirect && (beat_cnt >= skip_beat);
        skip_adv    = '0;
        if (beat_wr && (beat_cnt == skip_beat)) begin
            skip_adv = PTR_W'(skip[BOFF_W-1:0]);
        end
        wr_bytes    = beat_wr ? CNT_W'(BEAT_BYTES) : '0;
        free_bytes  = CNT_W'(BUF_BYTES) - count;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            req_pending <= 1'b0;
            req_line    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            stale       <= 1'b0;
            beat_cnt    <= '0;
            line_rip    <= line_align(entry, int'(LINE_BYTES));
            skip        <= OFF_W'(entry);
        end else begin
            // Buffer bookkeeping: a redirect empties the buffer and ignores consume.
            if (redirect) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                line_rip <= line_align(redirect_rip, int'(LINE_BYTES));
                skip     <= OFF_W'(redirect_rip);
            end else begin
                if (beat_wr) begin
                    wr_ptr <= wr_ptr + PTR_W'(BEAT_BYTES);
                end
                rd_ptr <= rd_ptr + skip_adv + PTR_W'(consume_eff);
                count  <= count + wr_bytes - CNT_W'(skip_adv) - CNT_W'(consume_eff);
            end

            case (state)
                IDLE: begin
                    if (!redirect && (free_bytes >= CNT_W'(LINE_BYTES))) begin
                        state       <= REQ;
                        req_pending <= 1'b1;
                        req_line    <= line_rip;
                    end
                end
                REQ: begin
                    // An issued request cannot be withdrawn; a redirect only marks it stale.
                    if (redirect) begin
                        stale <= 1'b1;
                    end
                    if (bus.req_ack) begin
                        req_pending <= 1'b0;
                        state       <= RESP;
                        beat_cnt    <= '0;
                    end
                end
                RESP: begin
                    if (redirect) begin
                        stale <= !last_beat;
                    end else if (last_beat) begin
                        stale <= 1'b0;
                        if (!stale) begin
                            line_rip <= line_rip + 64'(LINE_BYTES);
                            skip     <= '0;
                        end
                    end
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                        if (last_beat) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    fetch_ring_buffer #(
        .BUF_BYTES     (BUF_BYTES),
        .BEAT_BITS     (BEAT_BITS),
        .DECODE_WINDOW (DECODE_WINDOW)
    ) u_ring (
        .clk     (clk),
        .wr_en   (beat_wr),
        .wr_ptr  (wr_ptr),
        .wr_data (bus.resp_data),
        .rd_ptr  (rd_ptr),
        .window  (window_bytes)
    );

endmodule

// File: doc/fetch_stream_unit.md
Name: fetch_stream_unit

Overview:
Parametrised instruction-fetch front end for the core. It issues cache-line read requests on the system bus and drops leading bytes before the fetch target. Received beats go into a circular byte buffer, and a DECODE_WINDOW-byte window is presented to the decoder, which consumes a variable byte count each cycle. Compared with the previous fetch logic it adds configurable widths and depths, exact per-line beat counting, and a redirect/flush path that discards in-flight responses.

Parameters:
LINE_BYTES, 64, bytes per bus line request (power of 2)
BEAT_BITS, 64, response beat width; BEATS = LINE_BYTES*8/BEAT_BITS
BUF_BYTES, 128, circular buffer capacity (power of 2, >= 2*LINE_BYTES)
DECODE_WINDOW, 15, bytes presented to decoder per cycle
TAG_BITS, 13, bus request tag width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset (asserted when 0)
entry  in  64  start RIP, sampled while reset asserted
redirect  in  1  flush and restart fetch at redirect_rip
redirect_rip  in  64  new fetch target
req_cyc  out  1  bus request valid
req_addr  out  64  line-aligned request address
req_tag  out  TAG_BITS  {READ, MEMORY, 8'b0}
req_ack  in  1  bus accepted request
resp_cyc  in  1  response beat valid
resp_data  in  BEAT_BITS  beat, byte 0 in bits [7:0]
resp_ack  out  1  combinationally equal to resp_cyc
window_bytes  out  DECODE_WINDOW*8  byte i = buffer[(rd_ptr+i) mod BUF_BYTES], byte 0 in bits [7:0]
window_valid  out  $clog2(DECODE_WINDOW+1)  min(count, DECODE_WINDOW)
consume  in  $clog2(DECODE_WINDOW+1)  bytes retired this cycle

Behaviour:
- Reset (async, reset==0): state=IDLE; req_cyc=0; req_addr=0; rd_ptr=wr_ptr=0; count=0; stale=0; beat_cnt=0; line_rip=entry & ~(LINE_BYTES-1); skip=entry mod LINE_BYTES. Deasserting reset mid-transfer is legal. The bus side is reset too, so no drain is needed.
- States: IDLE -> REQ -> RESP -> IDLE.
  - IDLE -> REQ (registered, req_cyc=1) when BUF_BYTES-count >= LINE_BYTES and redirect=0.
  - REQ holds req_cyc, req_addr=line_rip and req_tag stable until req_ack; then req_cyc=0, state RESP, beat_cnt=0.
  - RESP counts beats. On beat BEATS-1: state IDLE, line_rip += LINE_BYTES, skip=0, stale=0.
- Beat at index b (offset b*BEAT_BYTES within the line):
  - Discarded if stale=1.
  - Discarded if (b+1)*BEAT_BYTES <= skip.
  - Otherwise all BEAT_BYTES bytes are written at wr_ptr, wr_ptr += BEAT_BYTES, count += BEAT_BYTES.
  - For the beat containing skip, rd_ptr is also advanced by skip mod BEAT_BYTES, and count grows only by the remainder.
- Consume: rd_ptr += consume and count -= consume in the same cycle; a simultaneous write nets count += written - consume. consume > window_valid is illegal: a bench assertion fires and the RTL clamps to window_valid.
- Pointers are $clog2(BUF_BYTES) bits and wrap naturally. count is $clog2(BUF_BYTES)+1 bits and never exceeds BUF_BYTES, guaranteed by the request threshold.
- Redirect (highest priority, one cycle) clears the buffer and restarts fetch:
  - rd_ptr=wr_ptr=0, count=0.
  - line_rip = redirect_rip & ~(LINE_BYTES-1); skip = redirect_rip mod LINE_BYTES.
  - If state is REQ or RESP: stale=1. The bus protocol forbids withdrawing req_cyc, so the pending request completes and its beats are dropped.
  - window_valid=0 on the following cycle. consume in the redirect cycle is ignored.
  - Redirect while stale=1 just updates line_rip/skip.
- line_rip is captured into req_addr at the IDLE->REQ transition, so the line issued after a stale line completes uses the redirected address.

Decomposition:
- fetch_pkg holds:
  - the fetch_state_t enum {IDLE, REQ, RESP};
  - the bus tag constants READ and MEMORY;
  - a helper function line_align().
- Sub-module fetch_ring_buffer (BUF_BYTES, BEAT_BITS, DECODE_WINDOW): byte array, write port of one beat at wr_ptr, rotate-read window at rd_ptr. Pointer/count bookkeeping stays in the parent.

Test Plan:
- Entry 0x1000, req_ack after 1 cycle, 8 beats: req_addr=0x1000. Window byte 0 = first byte of beat 0, window_valid=15, count=64. A second request for 0x1040 issues immediately.
- Entry 0x100A: beat 0 dropped, beat 1 written with rd_ptr=2. After the line, count=54 and window byte 0 = line byte 10.
- consume=0 always: after lines 0x1000 and 0x1040, count=128 and req_cyc stays 0. Then consume 15 per cycle: a new request (0x1080) is raised on the cycle after count falls to <=64.
- Redirect to 0x2004 after beat 3 of a line: the remaining 4 beats are discarded and window_valid=0. Next req_addr=0x2000; after that line, count=60 and window byte 0 = line byte 4.
- req_ack withheld 10 cycles: req_cyc, req_addr and req_tag stay stable every cycle. A redirect during the wait still completes that request and drops its beats.
- Wrap: with rd_ptr=120 and count=20, window bytes 0..7 come from addresses 120..127 and bytes 8..14 from 0..6. A beat write coinciding with consume=7 gives count=21.
